broadcast_voter: RTL and testbench

Registered majority voter between the four lockstep modules' broadcast buses and the proxy-address decode that feeds the timer and UART. Each cycle it compares the {strobe, address, data} bundles of all eligible modules and forwards the majority bundle. It tracks consecutive miscompares per module and latches a sticky per-module fault that excludes that module from later votes. It replaces fixed-priority selection on BROADCAST_OK alone with a content-checked selection.

---
 rtl/broadcast_voter.sv | 110 +++++++++++
 tb/tb_broadcast_voter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/broadcast_voter.sv
// Registered majority voter across four lockstep broadcast buses, with sticky per-module miscompare faults.
// Latency is 1 cycle and one vote is made per cycle. There are no stalls and no backpressure.
module broadcast_voter #(
  parameter int MISCOMPARE_LIMIT = 3,
  parameter int CNT_W            = 4
) (
  input  logic        CORE_CLK,
  input  logic        RST,
  input  logic [3:0]  MOD_OK_IN,
  input  logic [31:0] MOD_STROBE,
  input  logic [63:0] MOD_ADDRESS,
  input  logic [31:0] MOD_DATA,
  input  logic [3:0]  FAULT_CLEAR,
  output logic [7:0]  VOTE_STROBE,
  output logic [15:0] VOTE_ADDRESS,
  output logic [7:0]  VOTE_DATA,
  output logic        VOTE_VALID,
  output logic [3:0]  MODULE_FAULT,
  output logic        NO_MAJORITY
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MISCOMPARE_LIMIT);

  logic [3:0][31:0]      bundle;
  logic [3:0]            elig;
  logic [2:0]            elig_cnt;
  logic [3:0][2:0]       agree;
  logic [3:0]            cand;
  logic                  win_vld;
  logic [1:0]            win_idx;
  logic [31:0]           win_bundle;
  logic [3:0][CNT_W-1:0] miss_cnt;
  logic [3:0][CNT_W-1:0] miss_cnt_nxt;
  logic [3:0]            fault_nxt;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bundle[i] = {MOD_STROBE[8*i +: 8], MOD_ADDRESS[16*i +: 16], MOD_DATA[8*i +: 8]};
    end
  end

  // Agreement is counted only among eligible modules; a candidate needs a strict majority of E.
  always_comb begin
    elig     = MOD_OK_IN & ~MODULE_FAULT;
    elig_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      elig_cnt = elig_cnt + {2'b00, elig[i]};
    end
    for (int i = 0; i < 4; i++) begin
      agree[i] = '0;
      for (int j = 0; j < 4; j++) begin
        if (elig[j] && (bundle[j] == bundle[i])) agree[i] = agree[i] + 3'd1;
      end
      cand[i] = elig[i] && ({agree[i], 1'b0} > {1'b0, elig_cnt});
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i]) begin
        win_vld = 1'b1;
        win_idx = 2'(i);
      end
    end
    win_bundle = bundle[win_idx];
  end

  // A clear overrides any increment or fault set in the same cycle.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      miss_cnt_nxt[i] = miss_cnt[i];
      fault_nxt[i]    = MODULE_FAULT[i];
      if (win_vld && elig[i]) begin
        if (bundle[i] == win_bundle) begin
          miss_cnt_nxt[i] = '0;
        end else begin
          if (miss_cnt[i] < LIMIT) miss_cnt_nxt[i] = miss_cnt[i] + CNT_W'(1);
          if (miss_cnt_nxt[i] == LIMIT) fault_nxt[i] = 1'b1;
        end
      end
      if (FAULT_CLEAR[i]) begin
        miss_cnt_nxt[i] = '0;
        fault_nxt[i]    = 1'b0;
      end
    end
  end

  always_ff @(posedge CORE_CLK) begin
    if (RST) begin
      VOTE_STROBE  <= '0;
      VOTE_ADDRESS <= '0;
      VOTE_DATA    <= '0;
      VOTE_VALID   <= 1'b0;
      MODULE_FAULT <= '0;
      NO_MAJORITY  <= 1'b0;
      miss_cnt     <= '0;
    end else begin
      VOTE_STROBE  <= win_vld ? win_bundle[31:24] : 8'hEE;
      VOTE_ADDRESS <= win_vld ? win_bundle[23:8]  : 16'hEEEE;
      VOTE_DATA    <= win_vld ? win_bundle[7:0]   : 8'hEE;
      VOTE_VALID   <= win_vld;
      MODULE_FAULT <= fault_nxt;
      NO_MAJORITY  <= NO_MAJORITY | ~win_vld;
      miss_cnt     <= miss_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_broadcast_voter.sv
// Directed-vector bench for broadcast_voter. The driver queues hand-computed expectations and the monitor checks each one on the output cycle.
module tb_broadcast_voter;

  logic        CORE_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  MOD_OK_IN = '0;
  logic [31:0] MOD_STROBE = '0;
  logic [63:0] MOD_ADDRESS = '0;
  logic [31:0] MOD_DATA = '0;
  logic [3:0]  FAULT_CLEAR = '0;
  logic [7:0]  VOTE_STROBE;
  logic [15:0] VOTE_ADDRESS;
  logic [7:0]  VOTE_DATA;
  logic        VOTE_VALID;
  logic [3:0]  MODULE_FAULT;
  logic        NO_MAJORITY;

  broadcast_voter #(.MISCOMPARE_LIMIT(3), .CNT_W(4)) dut (
    .CORE_CLK(CORE_CLK), .RST(RST), .MOD_OK_IN(MOD_OK_IN),
    .MOD_STROBE(MOD_STROBE), .MOD_ADDRESS(MOD_ADDRESS), .MOD_DATA(MOD_DATA),
    .FAULT_CLEAR(FAULT_CLEAR), .VOTE_STROBE(VOTE_STROBE), .VOTE_ADDRESS(VOTE_ADDRESS),
    .VOTE_DATA(VOTE_DATA), .VOTE_VALID(VOTE_VALID), .MODULE_FAULT(MODULE_FAULT),
    .NO_MAJORITY(NO_MAJORITY)
  );

  always #5 CORE_CLK = ~CORE_CLK;

  typedef struct {
    int          cyc;
    int          id;
    logic [7:0]  s;
    logic [15:0] a;
    logic [7:0]  d;
    logic        v;
    logic [3:0]  f;
    logic        nm;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   vec_id = 0;

  always @(posedge CORE_CLK) cyc = cyc + 1;

  always @(negedge CORE_CLK) begin
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      tests = tests + 1;
      if (e.cyc != cyc || VOTE_STROBE !== e.s || VOTE_ADDRESS !== e.a || VOTE_DATA !== e.d ||
          VOTE_VALID !== e.v || MODULE_FAULT !== e.f || NO_MAJORITY !== e.nm) begin
        fails = fails + 1;
        $display("FAIL vec%0d: got s=%h a=%h d=%h v=%b f=%b nm=%b, want s=%h a=%h d=%h v=%b f=%b nm=%b",
                 e.id, VOTE_STROBE, VOTE_ADDRESS, VOTE_DATA, VOTE_VALID, MODULE_FAULT, NO_MAJORITY,
                 e.s, e.a, e.d, e.v, e.f, e.nm);
      end
    end
  end

  task automatic vec_full(input logic rst, input logic [3:0] ok, input logic [3:0] clr,
                          input logic [31:0] strb, input logic [63:0] addr, input logic [31:0] dat,
                          input logic [7:0] es, input logic [15:0] ea, input logic [7:0] ed,
                          input logic ev, input logic [3:0] ef, input logic enm);
    exp_t e;
    @(posedge CORE_CLK);
    #1;
    RST         = rst;
    MOD_OK_IN   = ok;
    FAULT_CLEAR = clr;
    MOD_STROBE  = strb;
    MOD_ADDRESS = addr;
    MOD_DATA    = dat;
    e.cyc = cyc + 1;
    e.id  = vec_id;
    e.s = es; e.a = ea; e.d = ed; e.v = ev; e.f = ef; e.nm = enm;
    exp_q.push_back(e);
    vec_id = vec_id + 1;
  endtask

  // Common strobe 11 / address 00C1 on all modules; per-module data d0..d3.
  task automatic vec(input logic rst, input logic [3:0] ok, input logic [3:0] clr,
                     input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                     input logic [7:0] ed, input logic ev, input logic [3:0] ef, input logic enm);
    logic [7:0]  es;
    logic [15:0] ea;
    es = ev ? 8'h11 : (rst ? 8'h00 : 8'hEE);
    ea = ev ? 16'h00C1 : (rst ? 16'h0000 : 16'hEEEE);
    vec_full(rst, ok, clr, {4{8'h11}}, {4{16'h00C1}}, {d3, d2, d1, d0}, es, ea, ed, ev, ef, enm);
  endtask

  initial begin
    // Reset
    vec(1, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 0, 4'h0, 0);
    vec(1, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 0, 4'h0, 0);
    // All agree
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    // Module 2 diverges: faulted on the third edge, then E=3 still votes
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 4'h4, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 1, 4'h4, 0);
    vec(0, 4'hF, 4'h4, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    // Module 1: 2 miss, 1 match, 2 miss -> no fault (counter ends at 2)
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);
    // 2-2 split; module 1 counter must still hold 2, so one more miss faults it
    vec(0, 4'hF, 4'h0, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hEE, 0, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 1, 4'h2, 1);
    vec(0, 4'hF, 4'h2, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 1);
    // Module 3 faults, then clear priority
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h8, 1);
    vec(0, 4'hF, 4'h8, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h8, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 1, 4'h8, 1);
    vec(0, 4'hF, 4'h8, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 1);
    // Module 0 miss count 2, then E=1 with garbage elsewhere, then one miss faults module 0
    vec(0, 4'hF, 4'h0, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 1);
    vec_full(0, 4'b1000, 4'h0, 32'h22334455, 64'h1234_ABCD_0F0F_5555, 32'h77010203,
             8'h22, 16'h1234, 8'h77, 1, 4'h0, 1);
    vec(0, 4'hF, 4'h0, 8'h5B, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h1, 1);
    // E=0, then E=2 disagreeing and agreeing
    vec(0, 4'h0, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hEE, 0, 4'h1, 1);
    vec(0, 4'hF, 4'h1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 1);
    vec(0, 4'b0011, 4'h0, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'hEE, 0, 4'h0, 1);
    vec(0, 4'b0110, 4'h0, 8'h00, 8'h5A, 8'h5A, 8'h00, 8'h5A, 1, 4'h0, 1);
    // Reset with clears asserted clears everything, including NO_MAJORITY
    vec(1, 4'hF, 4'hF, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h00, 0, 4'h0, 0);
    vec(0, 4'hF, 4'h0, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 1, 4'h0, 0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge CORE_CLK);
    @(negedge CORE_CLK);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL vec%0d: never checked, got nothing, want a compared output", e.id);
    end
    if (tests != vec_id) begin
      fails = fails + 1;
      $display("FAIL: %0d vectors queued but %0d checked", vec_id, tests);
    end
    if (VOTE_VALID !== 1'b1 || MODULE_FAULT !== 4'h0 || NO_MAJORITY !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL: final state v=%b f=%b nm=%b", VOTE_VALID, MODULE_FAULT, NO_MAJORITY);
    end
    if (VOTE_STROBE !== 8'h11 || VOTE_ADDRESS !== 16'h00C1 || VOTE_DATA !== 8'h5A) begin
      fails = fails + 1;
      $display("FAIL: final bundle s=%h a=%h d=%h", VOTE_STROBE, VOTE_ADDRESS, VOTE_DATA);
    end
    if (fails == 0) $display("[TB] PASS");
    else $display("[TB] FAIL");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
